// File: rtl/coeff_pkg.sv
// Shared types and constants for the coefficient register bank.
package coeff_pkg;

    localparam int IN_WIDTH    = 16;
    localparam int COEFF_WIDTH = 12;
    localparam int NUM_COEFF   = 3;

    typedef logic [COEFF_WIDTH-1:0] coeff_t;
    typedef logic [1:0]             coeff_sel_t;

    localparam coeff_sel_t SEL_C0 = 2'b00;
    localparam coeff_sel_t SEL_C1 = 2'b01;
    localparam coeff_sel_t SEL_C2 = 2'b10;

endpackage

// File: rtl/coeff_slot.sv
// One coefficient register with synchronous active-high reset and load enable.
module coeff_slot
    import coeff_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   ld_i,
    input  coeff_t d_i,
    output coeff_t q_o
);

    coeff_t q_q;
    coeff_t q_d;

    // Capture the new value when enabled, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (ld_i) begin
            q_d = d_i;
        end
    end

    // State register; reset wins over any pending load.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/coeff_reg.sv
// Bank of NUM_COEFF coefficient registers loaded one at a time over a narrow
// bus and presented in parallel as {coeff2, coeff1, coeff0}.
// Build option: define COEFF_SAT_EN to saturate the signed 16-bit input to the
// signed 12-bit range instead of truncating it.
module coeff_reg
    import coeff_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             coeff_ld,
    input  logic [IN_WIDTH-1:0]              coeff_in,
    input  coeff_sel_t                       coeff_sel,
    output logic [NUM_COEFF*COEFF_WIDTH-1:0] coeff_out
);

    coeff_t conv_val;

`ifdef COEFF_SAT_EN
    // Clamp a two's-complement input into the coefficient range. The value fits
    // when every bit above the coefficient's sign bit matches that sign bit.
    function automatic coeff_t sat_coeff(input logic [IN_WIDTH-1:0] raw);
        logic [IN_WIDTH-COEFF_WIDTH:0] top_bits;
        coeff_t                        result;
        top_bits = raw[IN_WIDTH-1:COEFF_WIDTH-1];
        if ((top_bits == '0) || (top_bits == '1)) begin
            result = raw[COEFF_WIDTH-1:0];
        end else if (raw[IN_WIDTH-1]) begin
            result = {1'b1, {(COEFF_WIDTH-1){1'b0}}};
        end else begin
            result = {1'b0, {(COEFF_WIDTH-1){1'b1}}};
        end
        return result;
    endfunction

    // Saturating conversion shared by every slot.
    always_comb begin
        conv_val = sat_coeff(coeff_in);
    end
`else
    // Upper input bits are intentionally dropped by truncation.
    logic unused_in_hi;
    assign unused_in_hi = ^coeff_in[IN_WIDTH-1:COEFF_WIDTH];

    // Truncating conversion shared by every slot.
    always_comb begin
        conv_val = coeff_in[COEFF_WIDTH-1:0];
    end
`endif

    coeff_t slot_q [NUM_COEFF];

    for (genvar i = 0; i < NUM_COEFF; i++) begin : g_slot
        logic slot_ld;
        // Select code 2'b11 matches no slot, so such loads are dropped.
        assign slot_ld = coeff_ld && (coeff_sel == coeff_sel_t'(i));

        coeff_slot u_slot (
            .clk  (clk),
            .rst  (rst),
            .ld_i (slot_ld),
            .d_i  (conv_val),
            .q_o  (slot_q[i])
        );

        assign coeff_out[i*COEFF_WIDTH +: COEFF_WIDTH] = slot_q[i];
    end

endmodule

// File: tb/tb_coeff_reg.sv
// Scoreboard bench for coeff_reg: stimulus pushes expected output words into a
// queue, a monitor pops and compares one entry per clock.
module tb_coeff_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        coeff_ld = 1'b0;
    logic [15:0] coeff_in = 16'd0;
    logic [1:0]  coeff_sel = 2'd0;
    logic [35:0] coeff_out;

    typedef struct {
        string       name;
        logic [63:0] exp;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [63:0] last_exp;
    bit          have_last = 1'b0;
    int          model[3];
    int          n_chk = 0;
    int          n_fail = 0;

    coeff_reg dut (
        .clk       (clk),
        .rst       (rst),
        .coeff_ld  (coeff_ld),
        .coeff_in  (coeff_in),
        .coeff_sel (coeff_sel),
        .coeff_out (coeff_out)
    );

    always #5 clk = ~clk;

    // Reference conversion expressed numerically.
    function automatic int conv(input logic [15:0] din);
        int v;
`ifdef COEFF_SAT_EN
        v = int'($signed(din));
        if (v > 2047)       return 2047;
        else if (v < -2048) return 2048;
        else                return v & 4095;
`else
        v = int'(din);
        return v % 4096;
`endif
    endfunction

    function automatic logic [63:0] packed_model();
        longint s;
        s = longint'(model[0]) + longint'(model[1]) * 4096
          + longint'(model[2]) * 4096 * 4096;
        return 64'(s);
    endfunction

    task automatic step(input logic r, input logic ld, input logic [1:0] sel,
                        input logic [15:0] din, input string nm);
        @(negedge clk);
        rst       = r;
        coeff_ld  = ld;
        coeff_sel = sel;
        coeff_in  = din;
        if (r) begin
            model[0] = 0; model[1] = 0; model[2] = 0;
        end else if (ld && sel != 2'd3) begin
            model[sel] = conv(din);
        end
        sb.push_back('{nm, packed_model()});
    endtask

    // Monitor: one expected word per clock, checked just after the edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            n_chk++;
            if ({28'd0, coeff_out} !== cur.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", cur.name, coeff_out, cur.exp[35:0]);
            end
            last_exp  = cur.exp;
            have_last = 1'b1;
        end
    end

    // Output must not move when inputs change between edges.
    always @(negedge clk) begin
        #1;
        if (have_last) begin
            n_chk++;
            if ({28'd0, coeff_out} !== last_exp) begin
                n_fail++;
                $display("FAIL hold_between_edges: got %h expected %h", coeff_out, last_exp[35:0]);
            end
        end
    end

    initial begin
        logic [15:0] r16;
        logic [1:0]  rsel;
        model[0] = 0; model[1] = 0; model[2] = 0;

        step(1, 1, 2'b00, 16'd500, "reset_cycle1");
        step(1, 1, 2'b00, 16'd500, "reset_cycle2");
        step(0, 0, 2'b00, 16'd68,  "ld_low_no_load");
        step(0, 1, 2'b00, 16'd68,  "ld_high_load68");
        step(1, 0, 2'b00, 16'd0,   "reset_again");
        step(0, 1, 2'b00, 16'd1,   "addr_c0");
        step(0, 1, 2'b01, 16'd2,   "addr_c1");
        step(0, 1, 2'b10, 16'd3,   "addr_c2");
        step(0, 1, 2'b11, 16'hABC, "unmapped_sel");
        step(0, 0, 2'b01, 16'hFFF, "ld_low_hold");
        step(1, 1, 2'b01, 16'd9,   "reset_priority");
        step(0, 1, 2'b00, 16'h1234, "conv_1234");
        step(0, 1, 2'b01, 16'hF000, "conv_F000");
        step(0, 1, 2'b10, 16'h07FF, "conv_07FF");
        step(0, 1, 2'b00, 16'hF800, "conv_F800");
        step(0, 1, 2'b01, 16'h0800, "conv_0800");
        step(0, 1, 2'b10, 16'hF7FF, "conv_F7FF");
        step(0, 1, 2'b00, 16'hFFFF, "conv_FFFF");

        for (int i = 0; i < 300; i++) begin
            r16  = 16'($urandom);
            rsel = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 rsel, r16, "random");
        end

        step(0, 0, 2'b00, 16'd0, "drain");
        @(posedge clk);
        @(posedge clk);
        #2;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
